// File: rtl/sbox_pass_sequencer.sv
// Burst sequencer for the four-S-box power-analysis datapath: idle gap, LFSR advance, chained passes.
// Define SBOX_SEQ_FREERUN_EN for free-running re-arm; default is single-shot on start.
module sbox_pass_sequencer #(
    parameter int unsigned IDLE_CYCLES = 11,
    parameter int unsigned NUM_PASSES  = 4
) (
    input  logic       ICE_CLK,
    input  logic       resetn,
    input  logic       start,
    input  logic       abort,
    output logic       lfsr_shift_en,
    output logic       text_in_sel,
    output logic       text_reg_en,
    output logic       trigger,
    output logic       busy,
    output logic       done,
    output logic [3:0] pass_idx
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_ADVANCE,
        ST_PASS,
        ST_DONE
    } state_e;

    localparam logic [7:0] GapLoad  = (IDLE_CYCLES == 0) ? 8'd0 : 8'(IDLE_CYCLES - 1);
    localparam logic [3:0] LastPass = 4'(NUM_PASSES - 1);
    localparam state_e     ArmState = (IDLE_CYCLES == 0) ? ST_ADVANCE : ST_GAP;

    state_e     state_q, state_d;
    logic [7:0] gapCnt_q, gapCnt_d;
    logic [3:0] passIdx_q, passIdx_d;
    logic       launch;

`ifdef SBOX_SEQ_FREERUN_EN
    // Free-running: IDLE only lasts one cycle (after reset or abort) before re-arming.
    logic unusedStart;
    assign unusedStart = start;
    assign launch      = 1'b1;
`else
    assign launch      = start;
`endif

    always_ff @(posedge ICE_CLK or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            gapCnt_q  <= 8'd0;
            passIdx_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            gapCnt_q  <= gapCnt_d;
            passIdx_q <= passIdx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gapCnt_d  = gapCnt_q;
        passIdx_d = passIdx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d  = ArmState;
                    gapCnt_d = GapLoad;
                end
            end
            ST_GAP: begin
                if (gapCnt_q == 8'd0) begin
                    state_d = ST_ADVANCE;
                end else begin
                    gapCnt_d = gapCnt_q - 8'd1;
                end
            end
            ST_ADVANCE: begin
                state_d   = ST_PASS;
                passIdx_d = 4'd0;
            end
            ST_PASS: begin
                if (passIdx_q == LastPass) begin
                    state_d   = ST_DONE;
                    passIdx_d = 4'd0;
                end else begin
                    passIdx_d = passIdx_q + 4'd1;
                end
            end
            ST_DONE: begin
`ifdef SBOX_SEQ_FREERUN_EN
                state_d  = ArmState;
                gapCnt_d = GapLoad;
`else
                state_d  = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides every transition above but is meaningless while already idle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            gapCnt_d  = 8'd0;
            passIdx_d = 4'd0;
        end
    end

    always_comb begin
        lfsr_shift_en = 1'b0;
        text_in_sel   = 1'b0;
        text_reg_en   = 1'b0;
        trigger       = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        pass_idx      = 4'd0;
        unique case (state_q)
            ST_IDLE: begin
            end
            ST_GAP: begin
                busy = 1'b1;
            end
            ST_ADVANCE: begin
                busy          = 1'b1;
                lfsr_shift_en = 1'b1;
            end
            ST_PASS: begin
                // Pass 0 consumes fresh LFSR text; later passes chain the previous S-box result.
                busy        = 1'b1;
                text_reg_en = 1'b1;
                trigger     = 1'b1;
                text_in_sel = (passIdx_q != 4'd0);
                pass_idx    = passIdx_q;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifndef SYNTHESIS
    assert property (@(posedge ICE_CLK) disable iff (!resetn) !(lfsr_shift_en && text_reg_en));
`endif

endmodule
